// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - decode-stage register file, load-use hazard detect and decode->EX pipeline register
module decode_pipe_stage #(
  parameter int                 DATA_W  = 8,
  parameter int                 NREGS   = 4,
  parameter int                 SP_REG  = 3,
  parameter logic [DATA_W-1:0]  SP_INIT = 8'hFF,
  parameter int                 CTRL_W  = 24,
  localparam int                AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_wen,
  input  logic              is_load,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [1:0]        wb_wen,
  input  logic [AW-1:0]     wb_addr0,
  input  logic [AW-1:0]     wb_addr1,
  input  logic [DATA_W-1:0] wb_data0,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [AW-1:0]     ex_rs1_addr,
  output logic [AW-1:0]     ex_rs2_addr,
  output logic [AW-1:0]     ex_rd_addr,
  output logic              ex_rs1_used,
  output logic              ex_rs2_used,
  output logic              ex_rd_wen,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [15:0]       bubble_cnt
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rs1_data, rs2_data, ex_rs1_fwd, ex_rs2_fwd;

  // Later assignments take priority, so port1 overrides port0 on a shared address.
  always_comb begin
    rs1_data   = regs[rs1_addr];
    rs2_data   = regs[rs2_addr];
    ex_rs1_fwd = ex_rs1_data;
    ex_rs2_fwd = ex_rs2_data;
    if (wb_wen[0] && wb_addr0 == rs1_addr)    rs1_data   = wb_data0;
    if (wb_wen[1] && wb_addr1 == rs1_addr)    rs1_data   = wb_data1;
    if (wb_wen[0] && wb_addr0 == rs2_addr)    rs2_data   = wb_data0;
    if (wb_wen[1] && wb_addr1 == rs2_addr)    rs2_data   = wb_data1;
    if (wb_wen[0] && wb_addr0 == ex_rs1_addr) ex_rs1_fwd = wb_data0;
    if (wb_wen[1] && wb_addr1 == ex_rs1_addr) ex_rs1_fwd = wb_data1;
    if (wb_wen[0] && wb_addr0 == ex_rs2_addr) ex_rs2_fwd = wb_data0;
    if (wb_wen[1] && wb_addr1 == ex_rs2_addr) ex_rs2_fwd = wb_data1;
  end

  assign load_use_stall = in_valid & ex_valid & ex_is_load & ex_rd_wen &
                          ((rs1_used & (rs1_addr == ex_rd_addr)) |
                           (rs2_used & (rs2_addr == ex_rd_addr)));

  assign in_ready = in_valid & ~load_use_stall & ~ex_stall & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_REG) ? SP_INIT : '0;
    end else begin
      if (wb_wen[0]) regs[wb_addr0] <= wb_data0;
      if (wb_wen[1]) regs[wb_addr1] <= wb_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      ex_rd_wen   <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      // Held operands track WB so they are current when EX finally consumes them.
      if (ex_valid && ex_rs1_used) ex_rs1_data <= ex_rs1_fwd;
      if (ex_valid && ex_rs2_used) ex_rs2_data <= ex_rs2_fwd;
    end else if (load_use_stall) begin
      ex_valid <= 1'b0;
      if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end else begin
      ex_valid    <= in_valid;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_rs1_addr <= rs1_addr;
      ex_rs2_addr <= rs2_addr;
      ex_rd_addr  <= rd_addr;
      ex_rs1_used <= rs1_used;
      ex_rs2_used <= rs2_used;
      ex_rd_wen   <= rd_wen;
      ex_is_load  <= is_load;
      ex_ctrl     <= ctrl_in;
      ex_pc       <= pc_in;
      ex_imm      <= imm_in;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - directed and model-checked bench for decode_pipe_stage
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_used, rs2_used, rd_wen, is_load;
  logic [23:0] ctrl_in;
  logic [7:0]  pc_in, imm_in;
  logic [1:0]  wb_wen;
  logic [1:0]  wb_addr0, wb_addr1;
  logic [7:0]  wb_data0, wb_data1;
  logic        flush, ex_stall, load_use_stall, ex_valid;
  logic [7:0]  ex_rs1_data, ex_rs2_data, ex_pc, ex_imm;
  logic [1:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_rs1_used, ex_rs2_used, ex_rd_wen, ex_is_load;
  logic [23:0] ex_ctrl;
  logic [15:0] bubble_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  decode_pipe_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .is_load(is_load), .ctrl_in(ctrl_in),
    .pc_in(pc_in), .imm_in(imm_in), .wb_wen(wb_wen), .wb_addr0(wb_addr0),
    .wb_addr1(wb_addr1), .wb_data0(wb_data0), .wb_data1(wb_data1), .flush(flush),
    .ex_stall(ex_stall), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_rs1_used(ex_rs1_used),
    .ex_rs2_used(ex_rs2_used), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
  );

  // Reference model: architectural register file plus the instruction sitting in EX.
  logic [7:0]  m_rf [4];
  bit          m_v, m_u1, m_u2, m_wen, m_ld;
  logic [7:0]  m_d1, m_d2, m_pc, m_imm;
  logic [1:0]  m_a1, m_a2, m_rd;
  logic [23:0] m_ctrl;
  int          m_bub;

  function automatic logic [7:0] wb_view(input logic [1:0] a, input logic [7:0] base);
    if (wb_wen[1] && wb_addr1 == a) return wb_data1;
    if (wb_wen[0] && wb_addr0 == a) return wb_data0;
    return base;
  endfunction

  function automatic bit m_hazard();
    return in_valid && m_v && m_ld && m_wen &&
           ((rs1_used && rs1_addr == m_rd) || (rs2_used && rs2_addr == m_rd));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rf[0] = 8'h00; m_rf[1] = 8'h00; m_rf[2] = 8'h00; m_rf[3] = 8'hFF;
      m_v = 0; m_u1 = 0; m_u2 = 0; m_wen = 0; m_ld = 0;
      m_d1 = 0; m_d2 = 0; m_pc = 0; m_imm = 0; m_a1 = 0; m_a2 = 0; m_rd = 0;
      m_ctrl = 0; m_bub = 0;
    end else begin
      if (flush) m_v = 0;
      else if (ex_stall) begin
        if (m_v && m_u1) m_d1 = wb_view(m_a1, m_d1);
        if (m_v && m_u2) m_d2 = wb_view(m_a2, m_d2);
      end else if (m_hazard()) begin
        m_v = 0;
        if (m_bub < 65535) m_bub++;
      end else begin
        m_v = in_valid;
        m_d1 = wb_view(rs1_addr, m_rf[rs1_addr]);
        m_d2 = wb_view(rs2_addr, m_rf[rs2_addr]);
        m_a1 = rs1_addr; m_a2 = rs2_addr; m_rd = rd_addr;
        m_u1 = rs1_used; m_u2 = rs2_used; m_wen = rd_wen; m_ld = is_load;
        m_ctrl = ctrl_in; m_pc = pc_in; m_imm = imm_in;
      end
      if (wb_wen[0]) m_rf[wb_addr0] = wb_data0;
      if (wb_wen[1]) m_rf[wb_addr1] = wb_data1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("m_ex_valid", 32'(ex_valid), 32'(m_v));
      chk("m_bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
      chk("m_load_use_stall", 32'(load_use_stall), 32'(m_hazard()));
      chk("m_in_ready", 32'(in_ready), 32'(in_valid && !m_hazard() && !ex_stall));
      if (m_v) begin
        chk("m_ex_rs1_data", 32'(ex_rs1_data), 32'(m_d1));
        chk("m_ex_rs2_data", 32'(ex_rs2_data), 32'(m_d2));
        chk("m_ex_addrs", {26'd0, ex_rs1_addr, ex_rs2_addr, ex_rd_addr},
                          {26'd0, m_a1, m_a2, m_rd});
        chk("m_ex_flags", {28'd0, ex_rs1_used, ex_rs2_used, ex_rd_wen, ex_is_load},
                          {28'd0, 1'(m_u1), 1'(m_u2), 1'(m_wen), 1'(m_ld)});
        chk("m_ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("m_ex_pc_imm", {16'd0, ex_pc, ex_imm}, {16'd0, m_pc, m_imm});
      end
    end
  end

  task automatic idle();
    in_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    rd_addr = 0; rd_wen = 0; is_load = 0; ctrl_in = 0; pc_in = 0; imm_in = 0;
    wb_wen = 0; wb_addr0 = 0; wb_addr1 = 0; wb_data0 = 0; wb_data1 = 0;
    flush = 0; ex_stall = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    armed = 1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 0);
    chk("rst_ex_payload", {ex_rs1_data, ex_rs2_data, ex_pc, ex_imm}, 0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 0);

    // Reset contents: SP reads FF, R1/R2 read 0
    in_valid = 1; rs1_addr = 3; rs1_used = 1; rs2_addr = 1; rs2_used = 1;
    step();
    chk("rst_sp", 32'(ex_rs1_data), 32'h FF);
    chk("rst_r1", 32'(ex_rs2_data), 0);
    chk("issue_valid", 32'(ex_valid), 1);

    // Same-cycle bypass of WB port0
    idle();
    in_valid = 1; rs1_addr = 1; rs1_used = 1; ctrl_in = 24'hABCDEF; pc_in = 8'h10; imm_in = 8'h20;
    wb_wen = 2'b01; wb_addr0 = 1; wb_data0 = 8'h5A;
    step();
    chk("bypass_r1", 32'(ex_rs1_data), 32'h5A);
    chk("ctrl_pass", 32'(ex_ctrl), 32'hABCDEF);

    // Dual write to R2, port1 wins
    idle();
    wb_wen = 2'b11; wb_addr0 = 2; wb_data0 = 8'h11; wb_addr1 = 2; wb_data1 = 8'h22;
    step();
    idle();
    in_valid = 1; rs1_addr = 2; rs1_used = 1; rs2_addr = 1; rs2_used = 1;
    step();
    chk("dual_wr_r2", 32'(ex_rs1_data), 32'h22);
    chk("array_r1", 32'(ex_rs2_data), 32'h5A);

    // Load-use: load R1 then consumer of R1 on rs2
    idle();
    in_valid = 1; is_load = 1; rd_addr = 1; rd_wen = 1;
    step();
    idle();
    in_valid = 1; rs2_addr = 1; rs2_used = 1;
    #1;
    chk("lu_stall", 32'(load_use_stall), 1);
    chk("lu_in_ready", 32'(in_ready), 0);
    step();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 1);
    chk("lu_ready_after", 32'(in_ready), 1);
    step();
    chk("lu_issue", 32'(ex_valid), 1);
    chk("lu_issue_data", 32'(ex_rs2_data), 32'h5A);

    // Held operand refreshed by WB during ex_stall
    idle();
    in_valid = 1; rs1_addr = 0; rs1_used = 1;
    step();
    ex_stall = 1; wb_wen = 2'b01; wb_addr0 = 0; wb_data0 = 8'h7E;
    step();
    chk("stall_refresh", 32'(ex_rs1_data), 32'h7E);
    chk("stall_valid", 32'(ex_valid), 1);
    wb_wen = 0;
    step();
    chk("stall_hold", 32'(ex_rs1_data), 32'h7E);

    // Flush beats ex_stall and hazard; no bubble counted
    idle();
    in_valid = 1; is_load = 1; rd_addr = 2; rd_wen = 1;
    step();
    idle();
    in_valid = 1; rs1_addr = 2; rs1_used = 1; ex_stall = 1; flush = 1;
    #1;
    chk("flush_hazard_seen", 32'(load_use_stall), 1);
    step();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_bubble_cnt", 32'(bubble_cnt), 1);

    // Non-load producer never raises a hazard
    idle();
    in_valid = 1; rd_addr = 3; rd_wen = 1;
    step();
    idle();
    in_valid = 1; rs1_addr = 3; rs1_used = 1;
    #1;
    chk("nonload_no_hazard", 32'(load_use_stall), 0);
    step();

    // Mixed traffic checked against the model only
    for (int i = 0; i < 60; i++) begin
      idle();
      in_valid = ($urandom_range(3) != 0);
      rs1_addr = 2'($urandom); rs2_addr = 2'($urandom); rd_addr = 2'($urandom);
      rs1_used = 1'($urandom); rs2_used = 1'($urandom); rd_wen = 1'($urandom);
      is_load = 1'($urandom); ctrl_in = 24'($urandom); pc_in = 8'($urandom); imm_in = 8'($urandom);
      wb_wen = 2'($urandom); wb_addr0 = 2'($urandom); wb_addr1 = 2'($urandom);
      wb_data0 = 8'($urandom); wb_data1 = 8'($urandom);
      flush = ($urandom_range(7) == 0);
      ex_stall = ($urandom_range(3) == 0);
      step();
    end

    // Reset mid-operation clears EX and register file
    idle();
    wb_wen = 2'b01; wb_addr0 = 1; wb_data0 = 8'h33;
    in_valid = 1; rs1_addr = 1; rs1_used = 1;
    step();
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("midrst_valid", 32'(ex_valid), 0);
    chk("midrst_bubble", 32'(bubble_cnt), 0);
    in_valid = 1; rs1_addr = 1; rs1_used = 1; rs2_addr = 3; rs2_used = 1;
    step();
    chk("midrst_r1", 32'(ex_rs1_data), 0);
    chk("midrst_sp", 32'(ex_rs2_data), 32'hFF);
    idle();
    step();

    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
